slice_scheduler: RTL and testbench
==================================

// Module: slice_scheduler
// PURPOSE
//   Shares one 16-lane slice datapath between NUM_REQ requesters. Each request is a
//   (start,end) index range over the 64-entry input vector. Round-robin arbitration
//   picks a requester; ranges longer than 16 are split into 16-wide chunks issued
//   back-to-back. Chunk completions are forwarded downstream with requester ID, chunk
//   number and last flag. Sits between the data-ops command queue and the slice datapath.
// PARAMETERS
//   NUM_REQ  4  number of requesters (2..8)
//   IDX_W    6  index width (vector length 2**IDX_W)
//   ID_W     2  requester ID width, >= clog2(NUM_REQ)
//   CHUNK    16 lanes per slice pass; fixed, matches datapath
// PORTS
//   clk           in   1              clock, all logic rising-edge
//   rst           in   1              synchronous reset, active-high
//   req_valid     in   NUM_REQ        per-requester command valid
//   req_ready     out  NUM_REQ        one-hot grant/accept, 1-cycle pulse
//   req_start     in   NUM_REQ*IDX_W  packed start index, requester i at [i*IDX_W +: IDX_W]
//   req_end       in   NUM_REQ*IDX_W  packed end index (inclusive)
//   su_valid      out  1              to datapath valid_in
//   su_ready      in   1              from datapath ready_in
//   su_start_idx  out  IDX_W          chunk start to datapath
//   su_end_idx    out  IDX_W          chunk end to datapath
//   su_out_valid  in   1              datapath result valid
//   su_out_ready  out  1              datapath result ready
//   rsp_valid     out  1              completion/error valid to consumer
//   rsp_ready     in   1              consumer ready
//   rsp_id        out  ID_W           requester ID of current command
//   rsp_chunk     out  IDX_W-4        chunk number within command, 0-based
//   rsp_last      out  1              final chunk (or error) of command
//   rsp_err       out  1              command rejected, start > end
//   busy          out  1              state != IDLE
// BEHAVIOUR
//   States: IDLE, ISSUE, WAIT, ERR. rst: state=IDLE, rr_ptr=0, all outputs 0.
//   IDLE: grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//     req_ready[grant]=1 that cycle only (combinational from state, registers).
//     Capture id, cur=start, end, chunk=0. Go to ISSUE if start<=end, else ERR.
//     No request: stay IDLE, req_ready=0.
//   ISSUE: su_valid=1; su_start_idx=cur; su_end_idx=min(end,cur+15).
//     Hold values stable until su_valid&&su_ready, then go to WAIT.
//   WAIT: rsp_valid = su_out_valid. su_out_ready = rsp_ready. rsp_id, rsp_chunk and
//     rsp_err=0 are held. rsp_last = (cur+16 > end); compute in IDX_W+1 bits with no wrap.
//     On su_out_valid&&rsp_ready:
//       last: go to IDLE, rr_ptr = id+1 mod NUM_REQ.
//       else: cur += 16, chunk += 1, go to ISSUE.
//   ERR: rsp_valid=1, rsp_err=1, rsp_last=1, rsp_chunk=0. Datapath untouched.
//     On rsp_ready: go to IDLE and advance rr_ptr as for last.
//   req_ready is 0 outside IDLE. Only one command is in flight; no preemption.
//   Latency: grant to su_valid is 1 cycle. Completion handshake to next ISSUE is 1 cycle.
//     Completion to next IDLE grant is 1 cycle.
//   su_valid, su_out_ready and rsp_valid are 0 in every state where not stated above.
//   Single entry (start==end) is one chunk, rsp_last=1. end=63,start=48 is one chunk.
//   rst mid-command: command dropped, no response, outputs 0 the next cycle.
//     The bench resets the datapath alongside.
// TESTING
//   1 req0 (0,40) alone -> su ranges (0,15),(16,31),(32,40); rsp_chunk 0,1,2; last on 2.
//   2 req0..3 all valid, single chunks -> grant order 0,1,2,3,0; one-hot req_ready pulses.
//   3 req2 (10,5) -> ERR: rsp_err=1, rsp_last=1; su_valid never asserted; rr_ptr=3.
//   4 rsp_ready low 5 cycles in WAIT -> su_out_ready=0, rsp_* stable, no further issue.
//   5 su_ready low 3 cycles in ISSUE -> su_valid, su_start_idx, su_end_idx held.
//     req (48,63) -> one chunk, last.
//   6 rst asserted in WAIT of a 3-chunk command -> next cycle IDLE, busy=0, outputs 0.
//     Next grant goes to req0.

Source files
------------

// File: rtl/slice_scheduler.sv
// slice_scheduler: round-robin arbiter that splits index ranges into 16-lane chunks for one slice datapath
module slice_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 6,
  parameter int ID_W    = 2,
  parameter int CHUNK   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*IDX_W-1:0] req_start,
  input  logic [NUM_REQ*IDX_W-1:0] req_end,
  output logic                     su_valid,
  input  logic                     su_ready,
  output logic [IDX_W-1:0]         su_start_idx,
  output logic [IDX_W-1:0]         su_end_idx,
  input  logic                     su_out_valid,
  output logic                     su_out_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [IDX_W-5:0]         rsp_chunk,
  output logic                     rsp_last,
  output logic                     rsp_err,
  output logic                     busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;
  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d, id_q, id_d, gnt, cand, nxt_id;
  logic [IDX_W-1:0] cur_q, cur_d, end_q, end_d, g_start, g_end;
  logic [IDX_W-5:0] chunk_q, chunk_d;
  logic [IDX_W:0]   cur_top, cur_nxt;
  logic             gnt_vld, last_c;
  always_comb begin
    gnt_vld = 1'b0;
    gnt = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt = cand;
      end
    end
  end
  assign g_start = req_start[int'(gnt)*IDX_W +: IDX_W];
  assign g_end   = req_end[int'(gnt)*IDX_W +: IDX_W];
  // Extra bit keeps cur+CHUNK from wrapping near the top of the vector
  assign cur_top = {1'b0, cur_q} + (IDX_W+1)'(CHUNK - 1);
  assign cur_nxt = {1'b0, cur_q} + (IDX_W+1)'(CHUNK);
  assign last_c  = cur_nxt > {1'b0, end_q};
  assign nxt_id  = (int'(id_q) == NUM_REQ - 1) ? '0 : id_q + 1'b1;
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    cur_d    = cur_q;
    end_d    = end_q;
    chunk_d  = chunk_q;
    case (state_q)
      IDLE: if (gnt_vld) begin
        id_d    = gnt;
        cur_d   = g_start;
        end_d   = g_end;
        chunk_d = '0;
        state_d = (g_start <= g_end) ? ISSUE : ERR;
      end
      ISSUE: state_d = su_ready ? WAIT : ISSUE;
      WAIT: if (su_out_valid && rsp_ready) begin
        state_d  = last_c ? IDLE : ISSUE;
        rr_ptr_d = last_c ? nxt_id : rr_ptr_q;
        cur_d    = last_c ? cur_q : cur_nxt[IDX_W-1:0];
        chunk_d  = last_c ? chunk_q : chunk_q + 1'b1;
      end
      default: if (rsp_ready) begin
        state_d  = IDLE;
        rr_ptr_d = nxt_id;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      cur_q    <= '0;
      end_q    <= '0;
      chunk_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      cur_q    <= cur_d;
      end_q    <= end_d;
      chunk_q  <= chunk_d;
    end
  end
  assign req_ready    = (state_q == IDLE && gnt_vld) ? NUM_REQ'(1) << gnt : '0;
  assign su_valid     = state_q == ISSUE;
  assign su_start_idx = su_valid ? cur_q : '0;
  assign su_end_idx   = !su_valid ? '0 : (cur_top > {1'b0, end_q}) ? end_q : cur_top[IDX_W-1:0];
  assign su_out_ready = state_q == WAIT && rsp_ready;
  assign rsp_valid    = (state_q == WAIT && su_out_valid) || state_q == ERR;
  assign rsp_id       = (state_q == WAIT || state_q == ERR) ? id_q : '0;
  assign rsp_chunk    = (state_q == WAIT) ? chunk_q : '0;
  assign rsp_last     = state_q == ERR || (state_q == WAIT && last_c);
  assign rsp_err      = state_q == ERR;
  assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_slice_scheduler.sv
// tb_slice_scheduler: directed self-checking bench for slice_scheduler
module tb_slice_scheduler;
  logic        clk, rst;
  logic [3:0]  req_valid, req_ready;
  logic [23:0] req_start, req_end;
  logic        su_valid, su_ready, su_out_valid, su_out_ready;
  logic [5:0]  su_start_idx, su_end_idx;
  logic        rsp_valid, rsp_ready, rsp_last, rsp_err, busy;
  logic [1:0]  rsp_id, rsp_chunk;
  int          checks = 0, errors = 0;
  slice_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_start(req_start), .req_end(req_end), .su_valid(su_valid), .su_ready(su_ready),
    .su_start_idx(su_start_idx), .su_end_idx(su_end_idx), .su_out_valid(su_out_valid),
    .su_out_ready(su_out_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_chunk(rsp_chunk), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_req(input int i, input int s, input int e);
    req_start[i*6 +: 6] = 6'(s);
    req_end[i*6 +: 6] = 6'(e);
    req_valid[i] = 1'b1;
  endtask
  // Entered in ISSUE; runs one chunk through the datapath and response handshakes
  task automatic do_chunk(input int s, input int e, input int c, input int last, input int id);
    chk("issue_valid", 32'(su_valid), 1);
    chk("issue_start", 32'(su_start_idx), 32'(s));
    chk("issue_end", 32'(su_end_idx), 32'(e));
    chk("issue_no_grant", 32'(req_ready), 0);
    su_ready = 1'b1;
    tick();
    su_ready = 1'b0;
    su_out_valid = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("wait_su_valid", 32'(su_valid), 0);
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("su_out_ready", 32'(su_out_ready), 1);
    chk("rsp_id", 32'(rsp_id), 32'(id));
    chk("rsp_chunk", 32'(rsp_chunk), 32'(c));
    chk("rsp_last", 32'(rsp_last), 32'(last));
    chk("rsp_err", 32'(rsp_err), 0);
    tick();
    su_out_valid = 1'b0;
    rsp_ready = 1'b0;
    #1;
  endtask
  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req_valid = '0;
    req_start = '0;
    req_end = '0;
    su_ready = 1'b0;
    su_out_valid = 1'b0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_su_valid", 32'(su_valid), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    // All four requesters with single-chunk ranges: grant order 0,1,2,3,0
    for (int i = 0; i < 4; i++) set_req(i, i * 4, i * 4 + 1);
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("rr_grant", 32'(req_ready), 32'(1) << order[n]);
      tick();
      do_chunk(order[n] * 4, order[n] * 4 + 1, 0, 1, order[n]);
    end
    req_valid = '0;
    #1;
    chk("idle_after_rr", 32'(busy), 0);
    // req0 (0,40) alone: three chunks
    set_req(0, 0, 40);
    #1;
    chk("t1_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    do_chunk(0, 15, 0, 0, 0);
    do_chunk(16, 31, 1, 0, 0);
    do_chunk(32, 40, 2, 1, 0);
    chk("t1_idle", 32'(busy), 0);
    // req2 (10,5): rejected without touching the datapath
    set_req(2, 10, 5);
    #1;
    chk("t3_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    #1;
    for (int n = 0; n < 2; n++) begin
      chk("err_su_valid", 32'(su_valid), 0);
      chk("err_rsp_valid", 32'(rsp_valid), 1);
      chk("err_flag", 32'(rsp_err), 1);
      chk("err_last", 32'(rsp_last), 1);
      chk("err_chunk", 32'(rsp_chunk), 0);
      chk("err_id", 32'(rsp_id), 2);
      chk("err_busy", 32'(busy), 1);
      if (n == 0) tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    // rr_ptr now 3: req3 beats req0; req3 (48,63) stalls 3 cycles on su_ready
    set_req(0, 0, 0);
    set_req(3, 48, 63);
    #1;
    chk("t3_rr_ptr", 32'(req_ready), 32'b1000);
    tick();
    req_valid[3] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      chk("stall_valid", 32'(su_valid), 1);
      chk("stall_start", 32'(su_start_idx), 48);
      chk("stall_end", 32'(su_end_idx), 63);
      tick();
    end
    do_chunk(48, 63, 0, 1, 3);
    // req0 (0,0): consumer backpressure for 5 cycles in WAIT
    chk("t4_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    #1;
    chk("t4_start", 32'(su_start_idx), 0);
    chk("t4_end", 32'(su_end_idx), 0);
    su_ready = 1'b1;
    tick();
    su_ready = 1'b0;
    su_out_valid = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      chk("bp_su_out_ready", 32'(su_out_ready), 0);
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_rsp_last", 32'(rsp_last), 1);
      chk("bp_rsp_id", 32'(rsp_id), 0);
      chk("bp_su_valid", 32'(su_valid), 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release", 32'(su_out_ready), 1);
    tick();
    rsp_ready = 1'b0;
    su_out_valid = 1'b0;
    #1;
    chk("t4_idle", 32'(busy), 0);
    // req1 (0,47): reset during WAIT of the second chunk
    set_req(1, 0, 47);
    #1;
    chk("t6_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    do_chunk(0, 15, 0, 0, 1);
    su_ready = 1'b1;
    tick();
    su_ready = 1'b0;
    chk("t6_wait_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_su_valid", 32'(su_valid), 0);
    chk("t6_rsp_valid", 32'(rsp_valid), 0);
    chk("t6_su_out_ready", 32'(su_out_ready), 0);
    chk("t6_req_ready", 32'(req_ready), 0);
    set_req(0, 0, 3);
    set_req(1, 0, 3);
    #1;
    chk("t6_rr_reset", 32'(req_ready), 32'b0001);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
